// File: rtl/traffic_light_fsm_param_if.sv
// traffic_light_fsm_param_if: bundles the traffic-light controller's strobes, requests and display/light outputs
// Ports (as signals):
//   tick_en, night_mode, ped_req_a, ped_req_b   controller inputs
//   A_lights, B_lights, Astate, Bstate          light bits and display codes
//   Acountdown, Bcountdown                      per-road countdowns (CNT_W bits)
//   ped_wait_a, ped_wait_b                      latched pedestrian requests
// Modports: master drives the inputs, slave is the controller.
interface traffic_light_fsm_param_if #(parameter int CNT_W = 7);
    logic             tick_en;
    logic             night_mode;
    logic             ped_req_a;
    logic             ped_req_b;
    logic [3:0]       A_lights;
    logic [3:0]       B_lights;
    logic [3:0]       Astate;
    logic [3:0]       Bstate;
    logic [CNT_W-1:0] Acountdown;
    logic [CNT_W-1:0] Bcountdown;
    logic             ped_wait_a;
    logic             ped_wait_b;
    modport master (
        output tick_en, night_mode, ped_req_a, ped_req_b,
        input  A_lights, B_lights, Astate, Bstate, Acountdown, Bcountdown, ped_wait_a, ped_wait_b
    );
    modport slave (
        input  tick_en, night_mode, ped_req_a, ped_req_b,
        output A_lights, B_lights, Astate, Bstate, Acountdown, Bcountdown, ped_wait_a, ped_wait_b
    );
endinterface

// File: rtl/traffic_light_fsm_param.sv
// traffic_light_fsm_param: two-road traffic light with all-red clearance, pedestrian shortening and flashing night mode
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  traffic_light_fsm_param_if.slave: tick_en/night_mode/ped_req_* in; lights, state codes,
//        saturated countdowns and ped_wait_* out (all outputs registered)
module traffic_light_fsm_param #(
    parameter int G_A_TIME = 25,
    parameter int G_B_TIME = 15,
    parameter int Y_TIME   = 5,
    parameter int R_TIME   = 2,
    parameter int PED_MIN  = 5,
    parameter int CNT_W    = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    traffic_light_fsm_param_if.slave       bus
);
    typedef enum logic [2:0] {AG, AY, AR, BG, BY, BR, NT} state_t;

    state_t           r_state, w_state;
    logic [31:0]      r_cnt, w_cnt;
    logic             r_flash, w_flash;
    logic             r_wait_a, w_wait_a, r_wait_b, w_wait_b;
    logic [3:0]       r_a_lights, r_b_lights, r_astate, r_bstate;
    logic [3:0]       w_a_lights, w_b_lights, w_astate, w_bstate;
    logic [CNT_W-1:0] r_acd, r_bcd;
    logic [31:0]      w_a_full, w_b_full;

    function automatic logic [CNT_W-1:0] sat(input logic [31:0] v);
        return ((v >> CNT_W) != 0) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
    endfunction

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_flash  = r_flash;
        w_wait_a = r_wait_a | (bus.ped_req_a && r_state != NT);
        w_wait_b = r_wait_b | (bus.ped_req_b && r_state != NT);
        if (bus.tick_en) begin
            // night entry outranks both phase expiry and pedestrian shortening
            if (r_state != NT && bus.night_mode) begin
                w_state  = NT;
                w_flash  = 1'b1;
                w_wait_a = 1'b0;
                w_wait_b = 1'b0;
            end else if (r_state == NT) begin
                if (bus.night_mode) w_flash = ~r_flash;
                else begin
                    w_state = BR;
                    w_cnt   = R_TIME;
                end
            end else if (r_cnt == 1) begin
                case (r_state)
                    AG:      begin w_state = AY; w_cnt = Y_TIME; w_wait_a = 1'b0; end
                    AY:      begin w_state = AR; w_cnt = R_TIME; end
                    AR:      begin w_state = BG; w_cnt = G_B_TIME; end
                    BG:      begin w_state = BY; w_cnt = Y_TIME; w_wait_b = 1'b0; end
                    BY:      begin w_state = BR; w_cnt = R_TIME; end
                    default: begin w_state = AG; w_cnt = G_A_TIME; end
                endcase
            end else if ((r_state == AG && r_wait_a || r_state == BG && r_wait_b) && r_cnt > PED_MIN) begin
                w_cnt = PED_MIN;
            end else begin
                w_cnt = r_cnt - 1;
            end
        end
    end

    // outputs decoded from the next state so the registered copies track the state register
    always_comb begin
        w_a_lights = 4'b0001;
        w_b_lights = 4'b0001;
        w_astate   = 4'd2;
        w_bstate   = 4'd2;
        w_a_full   = w_cnt;
        w_b_full   = w_cnt;
        case (w_state)
            AG: begin w_a_lights = 4'b0100; w_b_lights = 4'b1001; w_astate = 4'd0; w_b_full = w_cnt + Y_TIME + R_TIME; end
            AY: begin w_a_lights = 4'b0010; w_astate = 4'd1; w_b_full = w_cnt + R_TIME; end
            AR: w_a_full = w_cnt + G_B_TIME + Y_TIME + R_TIME;
            BG: begin w_b_lights = 4'b0100; w_a_lights = 4'b1001; w_bstate = 4'd0; w_a_full = w_cnt + Y_TIME + R_TIME; end
            BY: begin w_b_lights = 4'b0010; w_bstate = 4'd1; w_a_full = w_cnt + R_TIME; end
            BR: w_b_full = w_cnt + G_A_TIME + Y_TIME + R_TIME;
            default: begin
                w_a_lights = {2'b00, w_flash, 1'b0};
                w_b_lights = {2'b00, w_flash, 1'b0};
                w_astate   = 4'd3;
                w_bstate   = 4'd3;
                w_a_full   = '0;
                w_b_full   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= AG;
            r_cnt      <= G_A_TIME;
            r_flash    <= 1'b0;
            r_wait_a   <= 1'b0;
            r_wait_b   <= 1'b0;
            r_a_lights <= 4'b0100;
            r_b_lights <= 4'b0001;
            r_astate   <= 4'd0;
            r_bstate   <= 4'd2;
            r_acd      <= sat(32'(G_A_TIME));
            r_bcd      <= sat(32'(G_A_TIME + Y_TIME + R_TIME));
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_flash    <= w_flash;
            r_wait_a   <= w_wait_a;
            r_wait_b   <= w_wait_b;
            r_a_lights <= w_a_lights;
            r_b_lights <= w_b_lights;
            r_astate   <= w_astate;
            r_bstate   <= w_bstate;
            r_acd      <= sat(w_a_full);
            r_bcd      <= sat(w_b_full);
        end
    end

    assign bus.A_lights   = r_a_lights;
    assign bus.B_lights   = r_b_lights;
    assign bus.Astate     = r_astate;
    assign bus.Bstate     = r_bstate;
    assign bus.Acountdown = r_acd;
    assign bus.Bcountdown = r_bcd;
    assign bus.ped_wait_a = r_wait_a;
    assign bus.ped_wait_b = r_wait_b;
endmodule
